// File: rtl/fetch_decode_ctrl_pkg.sv
// fetch_decode_pkg
// Shared types and constants for the fetch/decode/execute controller:
// opcode and FSM state enums, ALU function codes, instruction field
// positions and a helper mapping an opcode to its execute state.
// No ports.

package fetch_decode_pkg;

    localparam int IW  = 16;
    localparam int DAW = 8;
    localparam int RAW = 4;

    // Instruction field positions
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int DA_MSB = 11;
    localparam int DA_LSB = 4;
    localparam int RA_MSB = 11;
    localparam int RA_LSB = 8;
    localparam int RB_MSB = 7;
    localparam int RB_LSB = 4;
    localparam int RD_MSB = 3;
    localparam int RD_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_t;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Undefined opcodes fall through to NOOP.
    function automatic state_t exec_state(input logic [3:0] op);
        state_t s;
        case (op)
            OP_STORE: s = ST_STORE;
            OP_LOAD:  s = ST_LOAD_A;
            OP_ADD:   s = ST_ADD;
            OP_SUB:   s = ST_SUB;
            OP_HALT:  s = ST_HALT;
            default:  s = ST_NOOP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// fetch_decode_ctrl_if
// Bundles the controller's bus toward PC, instruction ROM, data memory,
// register file and ALU, plus the display taps.
//   instr       ROM read data (into controller)
//   pc_clr/up   PC strobes
//   d_addr/d_wr data-memory address / write enable
//   rf_*        register-file select, addresses, write enable
//   alu_s       ALU function
//   ir/state    display taps
// master = controller side, slave = datapath/observer side.

interface fetch_decode_ctrl_if;
    import fetch_decode_pkg::*;

    logic [IW-1:0]  instr;
    logic           pc_clr;
    logic           pc_up;
    logic [DAW-1:0] d_addr;
    logic           d_wr;
    logic           rf_s;
    logic [RAW-1:0] rf_w_addr;
    logic           rf_w_en;
    logic [RAW-1:0] rf_ra_addr;
    logic [RAW-1:0] rf_rb_addr;
    logic [2:0]     alu_s;
    logic [IW-1:0]  ir;
    logic [3:0]     state;

    modport master (
        input  instr,
        output pc_clr, pc_up, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s, ir, state
    );

    modport slave (
        output instr,
        input  pc_clr, pc_up, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s, ir, state
    );

endinterface

// File: rtl/fetch_decode_ctrl_instr_reg.sv
// instr_reg
// IW-bit load-enable register with synchronous clear (clear wins over load).
//   i_clk  clock
//   i_clr  synchronous clear, active high
//   i_ld   load enable
//   i_d    data in
//   o_q    register contents

module instr_reg #(
    parameter int IW = 16
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_ld,
    input  logic [IW-1:0] i_d,
    output logic [IW-1:0] o_q
);

    logic [IW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl
// Fetch/decode/execute controller. Drives PC clear/increment, latches the
// ROM word into the IR in FETCH, and issues one instruction's datapath
// controls per pass. Outputs are Moore: registered state plus IR decode.
//   i_clk    system clock
//   i_clear  synchronous active-high reset, forces INIT and IR=0
//   bus      fetch_decode_ctrl_if.master (ROM data in, all controls out)
//
// state   | meaning
// INIT    | clear PC; PC=0 settles for the ROM before first fetch
// FETCH   | IR <= instr, PC++
// DECODE  | idle cycle, also covers ROM latency for the next fetch
// NOOP    | nothing (also undefined opcodes)
// LOAD_A  | present data-memory address
// LOAD_B  | write data-memory read data into RF
// STORE   | write RF[IR[3:0]] (ALU pass) to data memory
// ADD     | RF[Rd] <= RF[Ra] + RF[Rb]
// SUB     | RF[Rd] <= RF[Ra] - RF[Rb]
// HALT    | parked until clear

module fetch_decode_ctrl
    import fetch_decode_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_clear,
    fetch_decode_ctrl_if.master bus
);

    state_t         r_state;
    state_t         w_next;
    logic           w_ir_ld;
    logic [IW-1:0]  w_ir;

    logic           w_pc_clr;
    logic           w_pc_up;
    logic [DAW-1:0] w_d_addr;
    logic           w_d_wr;
    logic           w_rf_s;
    logic [RAW-1:0] w_rf_w_addr;
    logic           w_rf_w_en;
    logic [RAW-1:0] w_rf_ra_addr;
    logic [RAW-1:0] w_rf_rb_addr;
    logic [2:0]     w_alu_s;

    instr_reg #(.IW(IW)) u_ir (
        .i_clk (i_clk),
        .i_clr (i_clear),
        .i_ld  (w_ir_ld),
        .i_d   (bus.instr),
        .o_q   (w_ir)
    );

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ir_ld      = 1'b0;
        w_pc_clr     = 1'b0;
        w_pc_up      = 1'b0;
        w_d_wr       = 1'b0;
        w_rf_s       = 1'b0;
        w_rf_w_en    = 1'b0;
        w_alu_s      = ALU_PASS;
        // Address fields always follow the IR; only enables are qualified.
        w_d_addr     = w_ir[DA_MSB:DA_LSB];
        w_rf_w_addr  = w_ir[RD_MSB:RD_LSB];
        w_rf_ra_addr = w_ir[RA_MSB:RA_LSB];
        w_rf_rb_addr = w_ir[RB_MSB:RB_LSB];

        case (r_state)
            ST_INIT: begin
                w_pc_clr = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_FETCH: begin
                w_ir_ld = 1'b1;
                w_pc_up = 1'b1;
                w_next  = ST_DECODE;
            end
            ST_DECODE: begin
                w_next = exec_state(w_ir[OP_MSB:OP_LSB]);
            end
            ST_NOOP: begin
                w_next = ST_FETCH;
            end
            ST_LOAD_A: begin
                w_next = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                w_rf_s    = 1'b1;
                w_rf_w_en = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_STORE: begin
                // Store source register sits in the low field, not Ra.
                w_rf_ra_addr = w_ir[RD_MSB:RD_LSB];
                w_d_wr       = 1'b1;
                w_next       = ST_FETCH;
            end
            ST_ADD: begin
                w_alu_s   = ALU_ADD;
                w_rf_w_en = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_SUB: begin
                w_alu_s   = ALU_SUB;
                w_rf_w_en = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

    assign bus.pc_clr     = w_pc_clr;
    assign bus.pc_up      = w_pc_up;
    assign bus.d_addr     = w_d_addr;
    assign bus.d_wr       = w_d_wr;
    assign bus.rf_s       = w_rf_s;
    assign bus.rf_w_addr  = w_rf_w_addr;
    assign bus.rf_w_en    = w_rf_w_en;
    assign bus.rf_ra_addr = w_rf_ra_addr;
    assign bus.rf_rb_addr = w_rf_rb_addr;
    assign bus.alu_s      = w_alu_s;
    assign bus.ir         = w_ir;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Testbench for fetch_decode_ctrl: ROM + PC model drives instr, a per-cycle
// expected trace of (state, IR) is built from each program at instruction
// level and outputs are derived from it; a few literal checks pin the model.

module tb_fetch_decode_ctrl;
    import fetch_decode_pkg::*;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    fetch_decode_ctrl_if bus();

    fetch_decode_ctrl dut (
        .i_clk   (clk),
        .i_clear (clear),
        .bus     (bus)
    );

    // PC + synchronous-read ROM
    logic [15:0] rom [128];
    logic [6:0]  pc = 7'd0;
    logic [15:0] instr_q = 16'h0000;
    assign bus.instr = instr_q;

    always @(posedge clk) begin
        if (bus.pc_clr)     pc <= 7'd0;
        else if (bus.pc_up) pc <= pc + 7'd1;
        instr_q <= rom[pc];
    end

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] prog[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          chk_en  = 1'b0;
    int          pcup_cnt = 0;
    int          wen_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [15:0] ir);
        exp_t e;
        e.st = st;
        e.ir = ir;
        exp_q.push_back(e);
    endtask

    // Instruction-level trace: every instruction is FETCH (old IR visible),
    // DECODE, then its execute state(s).
    task automatic build_trace(input int halt_cyc);
        logic [15:0] prev;
        prev = 16'h0000;
        push(4'd0, 16'h0000);
        foreach (prog[i]) begin
            logic [15:0] w;
            w = prog[i];
            push(4'd1, prev);
            push(4'd2, w);
            case (w[15:12])
                4'h1: push(4'd6, w);
                4'h2: begin push(4'd4, w); push(4'd5, w); end
                4'h3: push(4'd7, w);
                4'h4: push(4'd8, w);
                4'h5: begin
                    for (int k = 0; k < halt_cyc; k++) push(4'd9, w);
                end
                default: push(4'd3, w);
            endcase
            prev = w;
        end
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (chk_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.pc_up)   pcup_cnt++;
            if (bus.rf_w_en) wen_cnt++;
            check("state",     bus.state,     e.st);
            check("ir",        bus.ir,        e.ir);
            check("pc_clr",    bus.pc_clr,    e.st == 4'd0);
            check("pc_up",     bus.pc_up,     e.st == 4'd1);
            check("d_wr",      bus.d_wr,      e.st == 4'd6);
            check("rf_w_en",   bus.rf_w_en,   e.st == 4'd5 || e.st == 4'd7 || e.st == 4'd8);
            check("rf_s",      bus.rf_s,      e.st == 4'd5);
            check("alu_s",     bus.alu_s,     (e.st == 4'd7) ? 3'b001 : (e.st == 4'd8) ? 3'b010 : 3'b000);
            check("d_addr",    bus.d_addr,    e.ir[11:4]);
            check("rf_w_addr", bus.rf_w_addr, e.ir[3:0]);
            check("rf_rb",     bus.rf_rb_addr, e.ir[7:4]);
            if (e.st == 4'd6)
                check("rf_ra_store", bus.rf_ra_addr, e.ir[3:0]);
            if (e.st == 4'd7 || e.st == 4'd8)
                check("rf_ra_alu", bus.rf_ra_addr, e.ir[11:8]);
            check("clr_up_excl", bus.pc_clr & bus.pc_up, 1'b0);

            // Hand-computed literals
            if (e.st == 4'd5 && e.ir == 16'h21B5) begin
                check("lit_load_daddr", bus.d_addr, 8'h1B);
                check("lit_load_rfs",   bus.rf_s, 1'b1);
                check("lit_load_wa",    bus.rf_w_addr, 4'd5);
                check("lit_load_wen",   bus.rf_w_en, 1'b1);
            end
            if (e.st == 4'd6 && e.ir == 16'h1A43) begin
                check("lit_store_daddr", bus.d_addr, 8'hA4);
                check("lit_store_ra",    bus.rf_ra_addr, 4'd3);
                check("lit_store_dwr",   bus.d_wr, 1'b1);
                check("lit_store_wen",   bus.rf_w_en, 1'b0);
            end
            if ((e.st == 4'd7 && e.ir == 16'h3126) || (e.st == 4'd8 && e.ir == 16'h4126)) begin
                check("lit_alu_s",  bus.alu_s, (e.st == 4'd7) ? 3'b001 : 3'b010);
                check("lit_alu_ra", bus.rf_ra_addr, 4'd1);
                check("lit_alu_rb", bus.rf_rb_addr, 4'd2);
                check("lit_alu_wa", bus.rf_w_addr, 4'd6);
                check("lit_alu_wen", bus.rf_w_en, 1'b1);
            end
            if (e.st == 4'd3 && e.ir == 16'hF000) begin
                check("lit_noop_state", bus.state, 4'd3);
                check("lit_noop_en", {bus.d_wr, bus.rf_w_en, bus.pc_up, bus.pc_clr}, 4'b0000);
            end
            if (e.st == 4'd9)
                check("lit_halt_pcup", bus.pc_up, 1'b0);
        end
    end

    task automatic load_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        foreach (prog[i]) rom[i] = prog[i];
    endtask

    task automatic reset_and_start(input int halt_cyc);
        load_rom();
        clear = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", bus.state, 4'd0);
        check("rst_pcclr", bus.pc_clr, 1'b1);
        check("rst_ir",    bus.ir, 16'h0000);
        check("rst_en",    {bus.pc_up, bus.d_wr, bus.rf_w_en, bus.rf_s}, 4'b0000);
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        pcup_cnt = 0;
        wen_cnt  = 0;
        build_trace(halt_cyc);
        chk_en = 1'b1;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while (exp_q.size() > 0 && b < 300) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout actual=%0d required=0 entries left", name, exp_q.size());
            exp_q.delete();
        end
        chk_en = 1'b0;
    endtask

    initial begin
        // LOAD, then HALT
        prog = {16'h21B5, 16'h5000};
        reset_and_start(3);
        drain("load");
        check("load_pcup_cnt", pcup_cnt, 2);

        // STORE
        prog = {16'h1A43, 16'h5000};
        reset_and_start(3);
        drain("store");
        check("store_pcup_cnt", pcup_cnt, 2);

        // ADD, NOOP, SUB
        prog = {16'h3126, 16'h0000, 16'h4126, 16'h5000};
        reset_and_start(3);
        drain("addsub");
        check("addsub_pcup_cnt", pcup_cnt, 4);

        // Clear during LOAD_A
        prog = {16'h21B5};
        load_rom();
        clear = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        wen_cnt = 0;
        push(4'd0, 16'h0000);
        push(4'd1, 16'h0000);
        push(4'd2, 16'h21B5);
        push(4'd4, 16'h21B5);
        chk_en = 1'b1;
        drain("midrst");
        clear = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rf_w_en) wen_cnt++;
        end
        check("midrst_state",  bus.state, 4'd0);
        check("midrst_ir",     bus.ir, 16'h0000);
        check("midrst_wen_cnt", wen_cnt, 0);

        // Undefined opcode then HALT held 20 cycles, then clear
        prog = {16'hF000, 16'h5000};
        reset_and_start(20);
        drain("halt");
        check("halt_pcup_cnt", pcup_cnt, 2);
        check("halt_still", bus.state, 4'd9);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("halt_clear_state", bus.state, 4'd0);
        check("halt_clear_pcclr", bus.pc_clr, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
